// File: rtl/ram_march_bist.sv
// March BIST initiator for a single-port RAM: write P up, verify P up, write ~P down, verify ~P down.
// Reports pass/fail and holds the address, expected word and read word of the first miscompare.
module ram_march_bist #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_adr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_adr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL_P  = 3'd1;
  localparam logic [2:0] S_VER_P   = 3'd2;
  localparam logic [2:0] S_DRAIN_P = 3'd3;
  localparam logic [2:0] S_FILL_N  = 3'd4;
  localparam logic [2:0] S_VER_N   = 3'd5;
  localparam logic [2:0] S_DRAIN_N = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [ADDR_W-1:0] ADR_LAST   = '1;
  localparam logic [ADDR_W-1:0] ADR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(READ_LAT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] fail_adr_q, fail_adr_d;
  logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
  logic [DATA_W-1:0] fail_act_q, fail_act_d;

  // Compare pipeline: one stage per clock of RAM read latency.
  logic              pv_q [READ_LAT];
  logic              pv_d [READ_LAT];
  logic [ADDR_W-1:0] pa_q [READ_LAT];
  logic [ADDR_W-1:0] pa_d [READ_LAT];
  logic [DATA_W-1:0] pe_q [READ_LAT];
  logic [DATA_W-1:0] pe_d [READ_LAT];

  logic miscmp;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return SEED ^ DATA_W'(a);
  endfunction

  assign miscmp = pv_q[READ_LAT-1] && (ram_q != pe_q[READ_LAT-1]);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d    = state_q;
    adr_d      = adr_q;
    err_d      = err_q;
    fail_adr_d = fail_adr_q;
    fail_exp_d = fail_exp_q;
    fail_act_d = fail_act_q;

    pv_d[0] = (state_q == S_VER_P) || (state_q == S_VER_N);
    pa_d[0] = adr_q;
    pe_d[0] = (state_q == S_VER_N) ? ~pat(adr_q) : pat(adr_q);
    for (int i = 1; i < READ_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
      pe_d[i] = pe_q[i-1];
    end

    // Only the first miscompare is recorded; the err flag is sticky.
    if (miscmp && !err_q) begin
      err_d      = 1'b1;
      fail_adr_d = pa_q[READ_LAT-1];
      fail_exp_d = pe_q[READ_LAT-1];
      fail_act_d = ram_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_FILL_P;
          adr_d      = '0;
          err_d      = 1'b0;
          fail_adr_d = '0;
          fail_exp_d = '0;
          fail_act_d = '0;
          for (int i = 0; i < READ_LAT; i++) pv_d[i] = 1'b0;
        end
      end
      S_FILL_P: begin
        adr_d = adr_q + ADR_ONE;
        if (adr_q == ADR_LAST) state_d = S_VER_P;
      end
      S_VER_P: begin
        adr_d = adr_q + ADR_ONE;
        if (adr_q == ADR_LAST) state_d = S_DRAIN_P;
      end
      S_DRAIN_P: begin
        adr_d = adr_q + ADR_ONE;
        if (adr_q == DRAIN_LAST) begin
          state_d = S_FILL_N;
          adr_d   = ADR_LAST;
        end
      end
      S_FILL_N: begin
        adr_d = adr_q - ADR_ONE;
        if (adr_q == '0) state_d = S_VER_N;
      end
      S_VER_N: begin
        adr_d = adr_q - ADR_ONE;
        if (adr_q == '0) begin
          state_d = S_DRAIN_N;
          adr_d   = '0;
        end
      end
      S_DRAIN_N: begin
        adr_d = adr_q + ADR_ONE;
        if (adr_q == DRAIN_LAST) begin
          state_d = S_DONE;
          adr_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the compare pipeline is a handful of flops, not a RAM, so it is reset with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      err_q      <= 1'b0;
      fail_adr_q <= '0;
      fail_exp_q <= '0;
      fail_act_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        pe_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      adr_q      <= adr_d;
      err_q      <= err_d;
      fail_adr_q <= fail_adr_d;
      fail_exp_q <= fail_exp_d;
      fail_act_q <= fail_act_d;
      for (int i = 0; i < READ_LAT; i++) begin
        pv_q[i] <= pv_d[i];
        pa_q[i] <= pa_d[i];
        pe_q[i] <= pe_d[i];
      end
    end
  end

  // RAM port is decoded from registered state only, never from ram_q.
  always_comb begin
    ram_we   = 1'b0;
    ram_adr  = '0;
    ram_data = '0;
    case (state_q)
      S_FILL_P: begin
        ram_we   = 1'b1;
        ram_adr  = adr_q;
        ram_data = pat(adr_q);
      end
      S_FILL_N: begin
        ram_we   = 1'b1;
        ram_adr  = adr_q;
        ram_data = ~pat(adr_q);
      end
      S_VER_P, S_VER_N: ram_adr = adr_q;
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign pass     = done && !err_q;
  assign fail_adr = fail_adr_q;
  assign fail_exp = fail_exp_q;
  assign fail_act = fail_act_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist: behavioural RAMs with injectable stuck-at faults,
// a write scoreboard for the main instance, and result/timing checks at done.
module tb_ram_march_bist;

  logic clk;
  logic rst_n;
  logic start;
  logic start_b;

  logic [7:0] ram_data, ram_q;
  logic [5:0] ram_adr;
  logic       ram_we, busy, done, pass;
  logic [5:0] fail_adr;
  logic [7:0] fail_exp, fail_act;

  logic [7:0] ram_data_2, ram_q_2, ram_data_3, ram_q_3;
  logic [5:0] ram_adr_2, ram_adr_3, fail_adr_2, fail_adr_3;
  logic       ram_we_2, busy_2, done_2, pass_2;
  logic       ram_we_3, busy_3, done_3, pass_3;
  logic [7:0] fail_exp_2, fail_act_2, fail_exp_3, fail_act_3;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         edges;
    logic       pass;
    logic [5:0] fadr;
    logic [7:0] fexp;
    logic [7:0] fact;
  } res_t;

  logic [13:0] wq[$];
  res_t        rq[$];

  logic       f0_en, f1_en;
  logic [5:0] f0_adr, f1_adr;
  logic [7:0] f0_mask, f1_mask;

  ram_march_bist #(.DATA_W(8), .ADDR_W(6), .READ_LAT(1), .SEED(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_data(ram_data), .ram_adr(ram_adr), .ram_we(ram_we), .ram_q(ram_q),
    .busy(busy), .done(done), .pass(pass),
    .fail_adr(fail_adr), .fail_exp(fail_exp), .fail_act(fail_act)
  );

  ram_march_bist #(.DATA_W(8), .ADDR_W(6), .READ_LAT(2), .SEED(8'hA5)) dut_lat2 (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .ram_data(ram_data_2), .ram_adr(ram_adr_2), .ram_we(ram_we_2), .ram_q(ram_q_2),
    .busy(busy_2), .done(done_2), .pass(pass_2),
    .fail_adr(fail_adr_2), .fail_exp(fail_exp_2), .fail_act(fail_act_2)
  );

  ram_march_bist #(.DATA_W(8), .ADDR_W(6), .READ_LAT(1), .SEED(8'hA5)) dut_lat_bad (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .ram_data(ram_data_3), .ram_adr(ram_adr_3), .ram_we(ram_we_3), .ram_q(ram_q_3),
    .busy(busy_3), .done(done_3), .pass(pass_3),
    .fail_adr(fail_adr_3), .fail_exp(fail_exp_3), .fail_act(fail_act_3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Latency-1 RAM with optional stuck-at-0 bits on read.
  logic [7:0] mem1 [64];
  always @(posedge clk) begin
    logic [7:0] v;
    if (ram_we) mem1[ram_adr] <= ram_data;
    v = mem1[ram_adr];
    if (f0_en && ram_adr == f0_adr) v = v & ~f0_mask;
    if (f1_en && ram_adr == f1_adr) v = v & ~f1_mask;
    ram_q <= v;
  end

  // Two latency-2 RAMs, one per extra instance.
  logic [7:0] mem2 [64], mem3 [64];
  logic [7:0] q2a, q3a;
  always @(posedge clk) begin
    if (ram_we_2) mem2[ram_adr_2] <= ram_data_2;
    q2a     <= mem2[ram_adr_2];
    ram_q_2 <= q2a;
    if (ram_we_3) mem3[ram_adr_3] <= ram_data_3;
    q3a     <= mem3[ram_adr_3];
    ram_q_3 <= q3a;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every RAM write of the main instance must match the head of wq.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (wq.size() == 0) check("unexpected_write", 64'(wq.size()), 64'd1);
      else check("write", {50'd0, ram_adr, ram_data}, {50'd0, wq.pop_front()});
    end
  end

  task automatic push_writes();
    logic [7:0] p;
    for (int a = 0; a < 64; a++) begin
      p = 8'hA5 ^ 8'(a);
      wq.push_back({6'(a), p});
    end
    for (int a = 63; a >= 0; a--) begin
      p = ~(8'hA5 ^ 8'(a));
      wq.push_back({6'(a), p});
    end
  endtask

  task automatic push_result(input int edges, input logic ps, input logic [5:0] fa,
                             input logic [7:0] fe, input logic [7:0] fc);
    res_t r;
    r.edges = edges; r.pass = ps; r.fadr = fa; r.fexp = fe; r.fact = fc;
    rq.push_back(r);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic advance(input int from_edge, input int to_edge);
    for (int e = from_edge; e < to_edge; e++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int from_edge, output int at_edge);
    at_edge = from_edge;
    while (done !== 1'b1 && at_edge < 400) begin
      @(posedge clk);
      #1 at_edge++;
    end
  endtask

  task automatic check_result(input string tag, input int edges);
    res_t r;
    r = rq.pop_front();
    check({tag, "_edges"}, 64'(edges), 64'(r.edges));
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_pass"}, {63'd0, pass}, {63'd0, r.pass});
    check({tag, "_fail"}, {42'd0, fail_adr, fail_exp, fail_act}, {42'd0, r.fadr, r.fexp, r.fact});
    check({tag, "_writes_left"}, 64'(wq.size()), 64'd0);
  endtask

  initial begin
    int edges, d2, d3, e;
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0;
    f0_en = 1'b0; f1_en = 1'b0;
    f0_adr = '0; f1_adr = '0; f0_mask = '0; f1_mask = '0;

    #23;
    check("reset_outputs", {24'd0, ram_we, ram_adr, ram_data, busy, done, pass, fail_adr, fail_exp, fail_act}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    advance(0, 2);
    check("idle_after_reset", {61'd0, busy, done, ram_we}, 64'd0);

    // Bit 3 stuck-at-0 at address 5: only the ~P pass can see it.
    f0_en = 1'b1; f0_adr = 6'd5; f0_mask = 8'h08;
    push_writes();
    push_result(258, 1'b0, 6'd5, 8'h5F, 8'h57);
    pulse_start();
    check("first_write", {49'd0, busy, ram_we, ram_adr, ram_data}, {49'd0, 1'b1, 1'b1, 6'd0, 8'hA5});
    wait_done(0, edges);
    check_result("stuck_a5", edges);

    // Two P-phase faults: the earlier address must stay latched.
    f0_adr = 6'd10; f0_mask = 8'h01;
    f1_en = 1'b1; f1_adr = 6'd20; f1_mask = 8'h01;
    push_writes();
    push_result(258, 1'b0, 6'd10, 8'hAF, 8'hAE);
    pulse_start();
    check("restart_clears", {40'd0, done, pass, fail_adr, fail_exp, fail_act, busy}, 64'd1);
    advance(0, 140);
    check("first_fail_latched", {50'd0, fail_adr, fail_exp}, {50'd0, 6'd10, 8'hAF});
    wait_done(140, edges);
    check_result("two_faults", edges);

    // Fault-free run with an ignored start mid-test.
    f0_en = 1'b0; f1_en = 1'b0;
    push_writes();
    push_result(258, 1'b1, 6'd0, 8'h00, 8'h00);
    pulse_start();
    check("restart_clears_2", {40'd0, done, pass, fail_adr, fail_exp, fail_act}, 64'd0);
    advance(0, 63);
    check("last_fill_p", {49'd0, ram_we, ram_adr, ram_data}, {49'd0, 1'b1, 6'd63, 8'h9A});
    advance(63, 99);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_ignored", {49'd0, ram_we, ram_adr, busy, 7'd0}, {49'd0, 1'b0, 6'd36, 1'b1, 7'd0});
    wait_done(100, edges);
    check_result("clean", edges);

    // Reset in the middle of FILL_N aborts at once.
    push_writes();
    pulse_start();
    advance(0, 150);
    check("in_fill_n", {63'd0, ram_we}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_abort", {24'd0, ram_we, ram_adr, ram_data, busy, done, pass, fail_adr, fail_exp, fail_act}, 64'd0);
    wq.delete();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_under_reset", {62'd0, busy, ram_we}, 64'd0);
    advance(0, 3);
    @(negedge clk) rst_n = 1'b1;
    advance(0, 2);
    check("idle_after_abort", {62'd0, busy, done}, 64'd0);
    push_writes();
    push_result(258, 1'b1, 6'd0, 8'h00, 8'h00);
    pulse_start();
    wait_done(0, edges);
    check_result("after_abort", edges);

    // Latency-2 RAM: matched instance passes in 260 edges, mismatched one fails.
    @(negedge clk) start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    d2 = -1; d3 = -1; e = 0;
    while ((d2 < 0 || d3 < 0) && e < 400) begin
      @(posedge clk);
      #1 e++;
      if (done_2 === 1'b1 && d2 < 0) d2 = e;
      if (done_3 === 1'b1 && d3 < 0) d3 = e;
    end
    check("lat2_edges", 64'(d2), 64'd260);
    check("lat2_pass", {63'd0, pass_2}, 64'd1);
    check("lat_mismatch_edges", 64'(d3), 64'd258);
    check("lat_mismatch_pass", {63'd0, pass_3}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Built-in self-test initiator for the single-port RAM.
- Owns the RAM's data/adr/we inputs and observes q.
- Runs a four-sweep march: write P ascending, verify P ascending, write ~P descending, verify ~P descending.
- Reports pass/fail and captures the first miscompare. It sits between the RAM and a test/status register block and muxes onto the RAM port during test.

Parameters:
- DATA_W, 8, RAM word width
- ADDR_W, 6, RAM address width; DEPTH = 2**ADDR_W
- READ_LAT, 1, clocks from address presented with we=0 to valid q (1..4)
- SEED, 8'hA5, pattern seed, DATA_W bits

Ports:
- clk  in  1  rising-edge clock, shared with RAM
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins test when not busy
- ram_data  out  DATA_W  write data to RAM
- ram_adr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_q  in  DATA_W  RAM read data
- busy  out  1  test in progress
- done  out  1  test complete; held until next start or reset
- pass  out  1  valid when done=1; 1 = no miscompare
- fail_adr  out  ADDR_W  address of first miscompare
- fail_exp  out  DATA_W  expected word at first miscompare
- fail_act  out  DATA_W  ram_q at first miscompare

Behaviour:
- Pattern: P(a) = SEED ^ a, with a zero-extended or truncated to DATA_W. The inverted pattern is ~P(a).
- Reset (async, rst_n=0): state IDLE; all outputs 0, including ram_we=0, ram_adr=0 and ram_data=0. The compare pipeline and error flag are cleared.
- Reset asserted mid-test aborts immediately. No RAM write occurs after rst_n falls.
- States and transitions:
  - IDLE: moves to FILL_P on start.
  - FILL_P: moves to VER_P after DEPTH cycles.
  - VER_P: moves to DRAIN_P after DEPTH cycles.
  - DRAIN_P: moves to FILL_N after READ_LAT cycles.
  - FILL_N: moves to VER_N after DEPTH cycles.
  - VER_N: moves to DRAIN_N after DEPTH cycles.
  - DRAIN_N: moves to DONE after READ_LAT cycles.
  - DONE: moves to FILL_P on start.
- RAM port outputs are decoded from registered state and address counter only; there is no combinational path from ram_q to ram_*.
- FILL_P: ram_we=1; ram_adr steps 0..DEPTH-1, one per cycle; ram_data=P(adr).
- VER_P: ram_we=0; ram_adr steps 0..DEPTH-1; ram_data=0.
- FILL_N: ram_we=1; ram_adr steps DEPTH-1..0; ram_data=~P(adr).
- VER_N: ram_we=0; ram_adr steps DEPTH-1..0; ram_data=0.
- DRAIN and IDLE/DONE: ram_we=0, ram_adr=0, ram_data=0.
- Address counter wraps naturally. The state change occurs on the edge at which the counter reaches its terminal value.
- Compare pipeline: each VER read issues a READ_LAT-deep shift of {valid, adr, expected}. ram_q is compared when the tail valid=1. DRAIN states exist only to flush this pipeline.
- Miscompare handling:
  - The first miscompare sets the sticky err flag and latches fail_adr, fail_exp and fail_act.
  - Later miscompares do not overwrite the latched values.
  - The test runs to completion regardless.
- busy=1 in every state except IDLE and DONE.
- done=1 in DONE only; pass = ~err in DONE and 0 otherwise.
- Timing: done rises exactly 4*DEPTH + 2*READ_LAT edges after the edge that samples start. With defaults this is 258.
- start while busy=1 is ignored.
- start in DONE restarts the test:
  - done, pass, err and fail_* clear on the sampling edge.
  - FILL_P then begins at adr 0.
- start coincident with rst_n low: reset wins.

Test Plan:
- Fault-free behavioural RAM model with defaults, start pulse:
  - ram_we=1 at adr 0 with data 8'hA5 on the first cycle, and at adr 63 with 8'h9A.
  - done=1 and pass=1 exactly 258 edges after start; busy low again.
- Model with bit 3 stuck-at-0 at address 5:
  - P(5)=8'hA0 reads back correctly, since bit 3 is already 0.
  - ~P(5)=8'h5F reads back as 8'h57.
  - Required result: pass=0, fail_adr=5, fail_exp=8'h5F, fail_act=8'h57.
- Model with faults at addresses 10 and 20, both in the P phase:
  - fail_adr=10 in the P phase, not 20.
  - Stays latched through done.
- start pulsed again at cycle 100 mid-test: ignored, and done still occurs at edge 258. After done, a second start clears done/pass/fail_* and a repeat run passes.
- rst_n pulled low during FILL_N at cycle 150:
  - All outputs 0 asynchronously, with no further ram_we.
  - After release and a new start, a full pass in 258 edges.
- READ_LAT=2 with a model of matching latency: pass after 260 edges. The same model checked with READ_LAT=1 must report pass=0.
